// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset main controller (FSM sequencing, instruction decode, NZCV flags, condition check).
// Optional retired-instruction counter is built only when MC_PERF_CNT_EN is defined.
module mc_controller #(
  parameter int CNT_W         = 32,
  parameter bit HALT_ON_UNDEF = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic [3:0]       ALUFlags,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic             Halted,
  output logic [CNT_W-1:0] RetiredCnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  logic       next_pc_s, branch_s, reg_w_s, mem_w_s, alu_op_s, ir_write_s;
  logic [3:0] cmd_s, alu_ctl_dec_s;
  logic       no_write_s, no_write_eff_s, arith_s, s_eff_s;
  logic [1:0] flag_w_s;
  logic       condex_live_s, condex_s;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State, flags and the condition result carried from EXEC into ALUWB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = HALT_ON_UNDEF ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state control decode.
  always_comb begin
    next_pc_s  = 1'b0;
    branch_s   = 1'b0;
    reg_w_s    = 1'b0;
    mem_w_s    = 1'b0;
    alu_op_s   = 1'b0;
    ir_write_s = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        next_pc_s  = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        reg_w_s   = 1'b1;
        ResultSrc = 2'b01;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w_s = 1'b1;
      end
      S_EXECR: alu_op_s = 1'b1;
      S_EXECI: begin
        ALUSrcB  = 2'b01;
        alu_op_s = 1'b1;
      end
      S_ALUWB: reg_w_s = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch_s  = 1'b1;
      end
      default: begin
        ir_write_s = 1'b0;
      end
    endcase
  end

  // Data-processing command decode; CMP always sets flags and never writes back.
  always_comb begin
    cmd_s         = Funct[4:1];
    alu_ctl_dec_s = ALU_ADD;
    no_write_s    = 1'b0;
    arith_s       = 1'b0;
    case (cmd_s)
      4'b0100: begin alu_ctl_dec_s = ALU_ADD; arith_s = 1'b1; end
      4'b0010: begin alu_ctl_dec_s = ALU_SUB; arith_s = 1'b1; end
      4'b0000: alu_ctl_dec_s = ALU_AND;
      4'b1100: alu_ctl_dec_s = ALU_ORR;
      4'b1010: begin alu_ctl_dec_s = ALU_SUB; arith_s = 1'b1; no_write_s = 1'b1; end
      default: begin alu_ctl_dec_s = ALU_ADD; no_write_s = 1'b1; end
    endcase
    s_eff_s        = Funct[0] | (cmd_s == 4'b1010);
    flag_w_s       = {s_eff_s, s_eff_s & arith_s};
    no_write_eff_s = no_write_s & (Op == 2'b00);
  end

  // ALUWB reuses the EXEC-cycle verdict so an instruction never sees its own flag update.
  always_comb begin
    condex_live_s = cond_eval(Cond, flags_q);
    condex_d      = condex_live_s;
    if (state_q == S_ALUWB) begin
      condex_s = condex_q;
    end else begin
      condex_s = condex_live_s;
    end
  end

  // Flag update at the end of EXEC, split into NZ and CV halves.
  always_comb begin
    flags_d = flags_q;
    if (alu_op_s && condex_s) begin
      if (flag_w_s[1]) begin
        flags_d[3:2] = ALUFlags[3:2];
      end else begin
        flags_d[3:2] = flags_q[3:2];
      end
      if (flag_w_s[0]) begin
        flags_d[1:0] = ALUFlags[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  assign ALUControl = alu_op_s ? alu_ctl_dec_s : ALU_ADD;
  assign RegWrite   = reset & reg_w_s & condex_s & ~no_write_eff_s;
  assign MemWrite   = reset & mem_w_s & condex_s;
  assign IRWrite    = reset & ir_write_s;
  assign PCWrite    = reset & (next_pc_s | (branch_s & condex_s) | (RegWrite & (Rd == 4'hF)));
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
  assign Halted     = (state_q == S_HALT);

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count every return to FETCH; entering HALT is not a retirement.
  always_comb begin
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign RetiredCnt = cnt_q;
`else
  assign RetiredCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus randomized instruction stream
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_controller;
  localparam int CNT_W = 32;
`ifdef MC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       Cond, Rd, ALUFlags;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA, Halted;
  logic [1:0]       ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0]       ALUControl;
  logic [CNT_W-1:0] RetiredCnt;

  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  m_flags;
  int unsigned m_cnt;

  mc_controller #(.CNT_W(CNT_W), .HALT_ON_UNDEF(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Halted(Halted), .RetiredCnt(RetiredCnt)
  );

  always #5 clk = ~clk;

  // ARM condition codes evaluated directly from N,Z,C,V.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] dp_ctl(input logic [3:0] cmd);
    if (cmd == 4'b0010 || cmd == 4'b1010) return 4'b0001;
    if (cmd == 4'b0000) return 4'b0010;
    if (cmd == 4'b1100) return 4'b0011;
    return 4'b0000;
  endfunction

  function automatic bit dp_writes(input logic [3:0] cmd);
    return (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
  endfunction

  function automatic logic [18:0] got_vec();
    return {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, ImmSrc, RegSrc, Halted};
  endfunction

  // Expected controls for cycle k of an instruction, derived from its class.
  function automatic logic [18:0] exp_vec(input int k, input logic [1:0] op, input logic [5:0] fn,
                                          input logic [3:0] rd, input bit ce);
    logic pcw, irw, adr, memw, regw, srca, hlt;
    logic [1:0] res, srcb, rs;
    logic [3:0] alu;
    {pcw, irw, adr, memw, regw, srca, hlt} = 7'b0;
    res = 2'b00; srcb = 2'b00; alu = 4'b0000;
    rs = {op == 2'b01, op == 2'b10};
    if (k == 0) begin
      irw = 1'b1; pcw = 1'b1; srca = 1'b1; srcb = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      srca = 1'b1; srcb = 2'b10; res = 2'b10;
    end else if (op == 2'b00) begin
      if (k == 2) begin
        srcb = fn[5] ? 2'b01 : 2'b00;
        alu  = dp_ctl(fn[4:1]);
      end else begin
        regw = ce && dp_writes(fn[4:1]);
        pcw  = regw && (rd == 4'd15);
      end
    end else if (op == 2'b01) begin
      if (k == 2) srcb = 2'b01;
      else if (k == 3) begin adr = 1'b1; memw = ce && !fn[0]; end
      else begin res = 2'b01; regw = ce; pcw = ce && (rd == 4'd15); end
    end else if (op == 2'b10) begin
      srcb = 2'b01; res = 2'b10; pcw = ce;
    end else begin
      hlt = 1'b1;
    end
    return {pcw, irw, adr, memw, regw, res, srca, srcb, alu, op, rs, hlt};
  endfunction

  function automatic logic [18:0] exp_reset(input logic [1:0] op);
    return {5'b00000, 2'b10, 1'b1, 2'b10, 4'b0000, op, op == 2'b01, op == 2'b10, 1'b0};
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
    return PERF ? CNT_W'(m_cnt) : {CNT_W{1'b0}};
  endfunction

  // Runs one instruction from FETCH; called just after a rising edge.
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] af);
    int lat;
    bit ce, s_eff, arith;
    logic [18:0] e;
    ce = cond_ok(c, m_flags);
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    if (op == 2'b00 || op == 2'b01 && !fn[0]) lat = 4;
    else if (op == 2'b01) lat = 5;
    else if (op == 2'b10) lat = 3;
    else lat = 2;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (RetiredCnt !== exp_cnt()) begin
          failures++;
          $display("FAIL %s cnt got=%0d exp=%0d", name, RetiredCnt, exp_cnt());
        end
      end
      e = exp_vec(k, op, fn, rd, ce);
      checks++;
      if (got_vec() !== e) begin
        failures++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, k, got_vec(), e);
      end
      @(posedge clk); #1;
    end
    if (op == 2'b00 && ce) begin
      s_eff = fn[0] || (fn[4:1] == 4'b1010);
      arith = (fn[4:1] == 4'b0100) || (fn[4:1] == 4'b0010) || (fn[4:1] == 4'b1010);
      if (s_eff) m_flags[3:2] = af[3:2];
      if (s_eff && arith) m_flags[1:0] = af[1:0];
    end
    if (op != 2'b11) m_cnt++;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (got_vec() !== exp_reset(Op) || RetiredCnt !== {CNT_W{1'b0}}) begin
        failures++;
        $display("FAIL %s rst%0d got=%h/%0d exp=%h/0", name, i, got_vec(), RetiredCnt, exp_reset(Op));
      end
    end
    m_flags = 4'b0000; m_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== exp_reset(Op) || RetiredCnt !== {CNT_W{1'b0}}) begin
        failures++;
        $display("FAIL reset got=%h exp=%h", got_vec(), exp_reset(Op));
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_dataproc();
    run_instr("add_reg", 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);
    run_instr("orrs_imm", 4'hE, 2'b00, 6'b111001, 4'd2, 4'b1011);
    run_instr("subs_pc", 4'hE, 2'b00, 6'b000101, 4'd15, 4'b0011);
  endtask

  task automatic test_branch();
    run_instr("cmp_imm", 4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100);
    run_instr("beq", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run_instr("bne", 4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
  endtask

  task automatic test_mem();
    run_instr("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    run_instr("strne", 4'h1, 2'b01, 6'b011000, 4'd3, 4'b0000);
    run_instr("str", 4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
  endtask

  task automatic test_halt();
    logic [18:0] e;
    run_instr("undef", 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);
    e = exp_vec(2, 2'b11, 6'b000000, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (got_vec() !== e || RetiredCnt !== exp_cnt()) begin
        failures++;
        $display("FAIL halt%0d got=%h exp=%h", i, got_vec(), e);
      end
      @(posedge clk); #1;
    end
    do_reset("rst_halt");
  endtask

  task automatic test_reset_memadr();
    logic [18:0] e;
    run_instr("cmp_z", 4'hE, 2'b00, 6'b110101, 4'd0, 4'b0100);
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_vec(k, Op, Funct, Rd, 1'b1);
      checks++;
      if (got_vec() !== e) begin
        failures++;
        $display("FAIL ldr_part cyc%0d got=%h exp=%h", k, got_vec(), e);
      end
      if (k < 2) begin @(posedge clk); #1; end
    end
    do_reset("rst_memadr");
    run_instr("bne_after_rst", 4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    do_reset("rst_cnt");
    for (int i = 0; i < 3; i++) run_instr("add_b2b", 4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(0, 2));
      run_instr("rand", 4'($urandom), op, 6'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0; Cond = 4'h0; Op = 2'b00; Funct = 6'b0; Rd = 4'h0; ALUFlags = 4'h0;
    m_flags = 4'b0000; m_cnt = 0;
    test_reset();
    test_dataproc();
    test_branch();
    test_mem();
    test_halt();
    test_reset_memadr();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
